product_accumulator: RTL
========================

# product_accumulator

Sequential accumulation stage directly downstream of the 4x4 array multiplier. It accepts one 8-bit product per valid/ready handshake and sums a fixed-length group of LEN products into an ACC_W-bit result. The result is then presented on a valid/ready output port. Typical use is forming a 4-term dot product from successive multiplier results.

## Interface
- LEN, 4: number of products per group; legal range 1..16.
- ACC_W, 12: accumulator and result width; legal range ≥8. The default holds 16×225 = 3600 with no saturation.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- clr  input  1  synchronous abort; discards the partial group and returns to ACCUM with count=0, acc=0.
- in_valid  input  1  in_prod is valid this cycle.
- in_ready  output  1  block can accept a product.
- in_prod  input  8  unsigned product from the multiplier, 0..225.
- out_valid  output  1  out_sum holds a completed group.
- out_ready  input  1  consumer accepts out_sum.
- out_sum  output  ACC_W  registered group sum.
- out_ovf  output  1  the group saturated; valid with out_valid.

## Operation
- Two states.
  - ACCUM: in_ready=1, out_valid=0.
  - OUT: in_ready=0, out_valid=1.
- Internal registers: acc (ACC_W bits), cnt (5 bits), ovf (sticky).
- Input accept occurs when in_valid && in_ready (ACCUM only).
  - acc ← sat(acc + zero-extended in_prod).
  - ovf ← ovf | carry.
  - cnt ← cnt+1.
- sat: if the true sum exceeds 2^ACC_W−1, the result is 2^ACC_W−1 and the carry flag is set.
- Completing accept: the accept where cnt == LEN−1.
  - The final sum and ovf load into out_sum/out_ovf.
  - State → OUT.
  - acc, cnt, ovf clear in the same edge.
- OUT:
  - out_sum and out_ovf are held stable until out_ready.
  - On out_valid && out_ready, state → ACCUM.
  - in_prod is ignored in OUT regardless of in_valid.
- in_valid low in ACCUM: no state change. Gaps of any length are allowed.
- clr:
  - In ACCUM: clr has priority over a same-cycle accept. The product is dropped, acc=0, cnt=0, ovf=0.
  - In OUT: clr drops the pending result; out_valid goes to 0 next cycle and state → ACCUM.
- LEN=1: every accept completes a group.
- Reset values (asynchronous, on rst_n low):
  - state=ACCUM, acc=0, cnt=0, ovf=0
  - out_sum=0, out_ovf=0, out_valid=0
  - in_ready=1 after reset release
- Reset mid-group or mid-OUT discards everything; there is no partial output.

## Timing
- in_ready and out_valid are decoded from registered state only. There is no combinational path from out_ready or in_valid to either.
- Latency: out_valid rises on the cycle after the completing accept edge.
- Minimum group period is LEN+1 cycles: LEN accepts, then one OUT cycle with out_ready held high.
- Back-to-back: an out handshake at edge N means in_ready=1 from edge N onward; the next accept can occur at edge N+1.
- Simultaneous out handshake and clr in OUT: treated as a clr; the result counts as not delivered.
- out_sum/out_ovf change only on the completing accept edge or on reset.

## Test plan
- Basic group, LEN=4. Accept products 20, 165, 10, 0 on consecutive cycles with out_ready=1.
  - Required: out_valid one cycle after the 4th accept, out_sum=195 (0x0C3), out_ovf=0, in_ready=0 for exactly that cycle.
- Gaps and backpressure. in_valid alternates 1/0 over products 225, 225, 1, 1. Hold out_ready=0 for 3 cycles after out_valid.
  - Required: out_sum=452 and out_valid held stable for all 4 cycles.
  - Required: in_valid pulses during OUT are not accepted, and the next group starts from acc=0.
- Saturation, ACC_W=8. Accept 225×4.
  - Required: out_sum=255, out_ovf=1.
  - Required: the following group 1,2,3,4 yields out_sum=10, out_ovf=0 (sticky flag cleared).
- clr priority. After accepting 50 and 60, assert clr with in_valid=1 and in_prod=70. Then accept 1, 2, 3, 4.
  - Required: out_sum=10; 50, 60, 70 are all lost.
- Reset mid-group. After 2 accepts, pulse rst_n low asynchronously, off the clock edge.
  - Required: out_valid=0 and out_sum=0 immediately, and in_ready=1 after release.
  - Required: the next full group 5, 5, 5, 5 yields 20.
- LEN=1, out_ready tied 1. Stream 7, 8, 9 with in_valid held 1.
  - Required: outputs 7, 8, 9 and in_ready toggling 1/0 each cycle.

Source files
------------

// File: rtl/product_accumulator.sv
// Purpose: sums groups of LEN unsigned 8-bit multiplier products into a saturating ACC_W-bit result.
// Latency: out_valid rises the cycle after the completing accept; minimum group period is LEN+1 cycles.
// Backpressure: in_ready drops while a result waits in OUT; result held until out_ready (clr aborts).
module product_accumulator #(
    parameter int LEN   = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(LEN - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [4:0]       cnt;
    logic             ovf;

    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] sum_sat;
    logic             last;

    // One guard bit above the accumulator catches the carry for saturation.
    always_comb begin
        sum_ext = {1'b0, acc} + (ACC_W+1)'(in_prod);
        carry   = sum_ext[ACC_W];
        sum_sat = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    end

    assign last      = (cnt == LAST_CNT);
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else if (clr) begin
            // Abort wins over any same-cycle accept or output handshake; out_sum keeps its old value.
            state <= ST_ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        if (last) begin
                            out_sum <= sum_sat;
                            out_ovf <= ovf | carry;
                            state   <= ST_OUT;
                            acc     <= '0;
                            cnt     <= '0;
                            ovf     <= 1'b0;
                        end else begin
                            acc <= sum_sat;
                            ovf <= ovf | carry;
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule
